txepreambl: RTL and testbench
=============================

TXEPREAMBL -- requirements
Module: txepreambl

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning), one per line:
  PREAMBLE_NIBBLES, 15, count of 4'h5 nibbles sent before the SFD nibble (legal range 1-15)
  IFG_NIBBLES, 24, minimum i_ce-qualified cycles with o_v low between packets (legal range 1-31)
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset; ports (name direction width meaning), one per line:
  i_clk      input   1  sole clock, all state on rising edge
  i_reset_n  input   1  asynchronous active-low reset
  i_ce       input   1  nibble-rate clock enable; state and outputs change only on edges with i_ce high
  i_en       input   1  1 = insert preamble/SFD, 0 = pass-through; sampled only at packet start
  i_cancel   input   1  abort current packet
  i_v        input   1  upstream nibble valid; held with i_d until accepted
  i_d        input   4  upstream nibble
  o_rdy      output  1  upstream may advance; combinational from state only
  o_v        output  1  registered MII TX enable
  o_d        output  4  registered MII TX nibble
  o_busy     output  1  registered, high whenever state != IDLE

Function
REQ-003 Input nibble SHALL be accepted only on an edge with i_ce && i_v && o_rdy.
REQ-004 States SHALL be IDLE, PRE, SFD, DATA, DROP, GAP; o_rdy SHALL be 1 only in DATA and DROP.
REQ-005 IDLE: on ce edge with i_v=1, i_cancel=0, i_en=1 -> PRE, o_v<=1, o_d<=4'h5, preamble counter loaded so exactly PREAMBLE_NIBBLES ce-cycles of 4'h5 are emitted.
REQ-006 IDLE: on ce edge with i_v=1, i_cancel=0, i_en=0 -> DATA directly, o_v/o_d unchanged (low); first data nibble appears on next ce edge.
REQ-007 PRE: each ce edge emits 4'h5 and decrements counter; after the last, next ce edge emits o_d<=4'hd, o_v<=1 and moves SFD->DATA.
REQ-008 DATA: each ce edge with i_v=1 SHALL register o_v<=1, o_d<=i_d (one ce-cycle latency, no reordering, no loss).
REQ-009 DATA: ce edge with i_v=0 SHALL set o_v<=0, enter GAP, load gap counter.
REQ-010 GAP: o_v SHALL stay low for exactly IFG_NIBBLES ce-cycles counting from the first low cycle after the packet, then -> IDLE; i_v ignored (o_rdy=0).
REQ-011 i_cancel on a ce edge in PRE, SFD or DATA SHALL force o_v<=0 on that edge; if i_v=1 -> DROP, else -> GAP.
REQ-012 DROP: accept and discard nibbles (o_v=0) until ce edge with i_v=0, then -> GAP; the discarded nibbles' low cycles do not count toward IFG.
REQ-013 i_cancel in IDLE, GAP or DROP SHALL have no effect; in IDLE with i_v=1 it SHALL suppress packet start for that edge.
REQ-014 Cycles with i_ce=0 SHALL hold all state, counters and outputs; o_rdy remains state-derived.
REQ-015 i_en changes after packet start SHALL not affect the packet in progress.
REQ-016 o_d SHALL be don't-care-free: when o_v=0, o_d holds its last value.

Reset
REQ-017 Asserting i_reset_n low SHALL immediately force state IDLE, o_v=0, o_d=4'h0, o_busy=0, counters 0, o_rdy=0, including mid-packet.
REQ-018 After deassertion the first packet SHALL begin with no IFG wait.

Verification
REQ-019 i_ce=1 always, i_en=1, 4-nibble packet 1,2,3,4 -> o_v high 20 cycles: 15x 4'h5, 4'hd, 1,2,3,4; o_rdy low 16 cycles before first acceptance.
REQ-020 Back-to-back packets with i_v held high after first ends -> o_v low exactly 24 cycles, then second preamble begins.
REQ-021 i_ce pulsing 1-in-4, i_en=1 -> same nibble sequence as REQ-019, each o_d value held 4 clocks.
REQ-022 i_en=0, packet A,B,C -> o_v high 3 ce-cycles carrying A,B,C, no 5/d nibbles.
REQ-023 i_cancel during 3rd data nibble of 10-nibble packet -> o_v drops next edge, remaining 7 nibbles consumed with o_v=0, then 24-cycle gap.
REQ-024 i_reset_n low during PRE nibble 7 -> o_v=0 asynchronously; next i_v starts full 15-nibble preamble.

Source files
------------

// File: rtl/txepreambl.sv
// MII transmit preamble/SFD inserter.
// Upstream nibbles are wrapped with PREAMBLE_NIBBLES x 4'h5 and one 4'hd SFD
// nibble (or passed straight through when i_en is low at packet start). After
// each packet the block enforces an inter-frame gap of IFG_NIBBLES ce-cycles.
//
// Handshake: an upstream nibble is transferred on a rising edge where
// i_ce && i_v && o_rdy; i_v/i_d must be held until that edge. o_rdy depends
// only on the state register, never on i_v, so there is no combinational loop.
module txepreambl #(
    parameter int PREAMBLE_NIBBLES = 15,
    parameter int IFG_NIBBLES      = 24
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_ce,
    input  logic       i_en,
    input  logic       i_cancel,
    input  logic       i_v,
    input  logic [3:0] i_d,
    output logic       o_rdy,
    output logic       o_v,
    output logic [3:0] o_d,
    output logic       o_busy
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE  = 3'd1,
        S_SFD  = 3'd2,
        S_DATA = 3'd3,
        S_DROP = 3'd4,
        S_GAP  = 3'd5
    } state_t;

    // The start edge emits the first 4'h5, so PRE only has to emit the rest.
    localparam logic [3:0] PRE_LOAD = 4'(PREAMBLE_NIBBLES - 1);
    // The IDLE start edge is itself one low cycle, so GAP lasts one cycle less.
    localparam logic [4:0] GAP_LOAD = 5'(IFG_NIBBLES - 1);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_pre_cnt;
    logic [3:0] w_pre_cnt_nxt;
    logic [4:0] r_gap_cnt;
    logic [4:0] w_gap_cnt_nxt;
    logic       r_v;
    logic       w_v_nxt;
    logic [3:0] r_d;
    logic [3:0] w_d_nxt;
    logic       r_busy;
    state_t     w_gap_state;

    // Where a packet goes once it ends; a 1-cycle IFG is covered by IDLE alone.
    assign w_gap_state = (IFG_NIBBLES == 1) ? S_IDLE : S_GAP;

    // Next-state and next-output decode; everything holds when i_ce is low.
    always_comb begin
        w_state_nxt   = r_state;
        w_pre_cnt_nxt = r_pre_cnt;
        w_gap_cnt_nxt = r_gap_cnt;
        w_v_nxt       = r_v;
        w_d_nxt       = r_d;
        if (i_ce) begin
            case (r_state)
                S_IDLE: begin
                    if (i_v && !i_cancel) begin
                        if (i_en) begin
                            w_v_nxt = 1'b1;
                            w_d_nxt = 4'h5;
                            if (PREAMBLE_NIBBLES == 1) begin
                                w_state_nxt = S_SFD;
                            end else begin
                                w_state_nxt   = S_PRE;
                                w_pre_cnt_nxt = PRE_LOAD;
                            end
                        end else begin
                            w_state_nxt = S_DATA;
                        end
                    end
                end
                S_PRE, S_SFD: begin
                    if (i_cancel) begin
                        w_v_nxt       = 1'b0;
                        w_pre_cnt_nxt = 4'd0;
                        w_state_nxt   = i_v ? S_DROP : w_gap_state;
                        w_gap_cnt_nxt = GAP_LOAD;
                    end else if (r_state == S_SFD) begin
                        w_v_nxt     = 1'b1;
                        w_d_nxt     = 4'hd;
                        w_state_nxt = S_DATA;
                    end else begin
                        w_v_nxt       = 1'b1;
                        w_d_nxt       = 4'h5;
                        w_pre_cnt_nxt = r_pre_cnt - 4'd1;
                        if (r_pre_cnt == 4'd1) begin
                            w_state_nxt = S_SFD;
                        end
                    end
                end
                S_DATA: begin
                    if (i_cancel) begin
                        w_v_nxt       = 1'b0;
                        w_state_nxt   = i_v ? S_DROP : w_gap_state;
                        w_gap_cnt_nxt = GAP_LOAD;
                    end else if (i_v) begin
                        w_v_nxt = 1'b1;
                        w_d_nxt = i_d;
                    end else begin
                        w_v_nxt       = 1'b0;
                        w_state_nxt   = w_gap_state;
                        w_gap_cnt_nxt = GAP_LOAD;
                    end
                end
                S_DROP: begin
                    // Gap counting starts only once the discarded tail is gone.
                    if (!i_v) begin
                        w_state_nxt   = w_gap_state;
                        w_gap_cnt_nxt = GAP_LOAD;
                    end
                end
                S_GAP: begin
                    if (r_gap_cnt <= 5'd1) begin
                        w_state_nxt   = S_IDLE;
                        w_gap_cnt_nxt = 5'd0;
                    end else begin
                        w_gap_cnt_nxt = r_gap_cnt - 5'd1;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_v_nxt     = 1'b0;
                end
            endcase
        end
    end

    // State, counters and registered MII outputs.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state   <= S_IDLE;
            r_pre_cnt <= 4'd0;
            r_gap_cnt <= 5'd0;
            r_v       <= 1'b0;
            r_d       <= 4'h0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pre_cnt <= w_pre_cnt_nxt;
            r_gap_cnt <= w_gap_cnt_nxt;
            r_v       <= w_v_nxt;
            r_d       <= w_d_nxt;
            r_busy    <= (w_state_nxt != S_IDLE);
        end
    end

    assign o_rdy  = (r_state == S_DATA) || (r_state == S_DROP);
    assign o_v    = r_v;
    assign o_d    = r_d;
    assign o_busy = r_busy;

endmodule

// File: tb/tb_txepreambl.sv
// Directed bench for txepreambl: drives packets through a negedge driver,
// checks every emitted nibble against an expected queue, and checks gap
// lengths, ready latency, ce hold behaviour and asynchronous reset.
module tb_txepreambl;

    logic       i_clk = 1'b0;
    logic       i_reset_n;
    logic       i_ce;
    logic       i_en;
    logic       i_cancel;
    logic       i_v;
    logic [3:0] i_d;
    logic       o_rdy;
    logic       o_v;
    logic [3:0] o_d;
    logic       o_busy;

    int         checks   = 0;
    int         failures = 0;
    logic [3:0] exp_q[$];
    int         low_run  = 0;
    int         last_gap = 0;
    int         ce_div   = 1;
    int         ce_phase = 0;
    logic [4:0] prev_vd  = 5'd0;
    logic       mon_ce;
    int         rdy_low;

    txepreambl #(.PREAMBLE_NIBBLES(15), .IFG_NIBBLES(24)) dut (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_ce      (i_ce),
        .i_en      (i_en),
        .i_cancel  (i_cancel),
        .i_v       (i_v),
        .i_d       (i_d),
        .o_rdy     (o_rdy),
        .o_v       (o_v),
        .o_d       (o_d),
        .o_busy    (o_busy)
    );

    // Clock.
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Monitor: compare each emitted nibble, measure low runs, check holds.
    always @(posedge i_clk) begin
        mon_ce = i_ce;
        #1;
        if (i_reset_n) begin
            if (mon_ce) begin
                if (o_v) begin
                    if (exp_q.size() == 0) check("extra_nibble", 32'(exp_q.size()), 32'd1);
                    else check("nibble", {28'd0, o_d}, {28'd0, exp_q.pop_front()});
                    if (low_run > 0) last_gap = low_run;
                    low_run = 0;
                end else begin
                    low_run++;
                end
            end else begin
                check("ce_hold", {27'd0, o_v, o_d}, {27'd0, prev_vd});
            end
        end
        prev_vd = {o_v, o_d};
    end

    // One driver cycle: move to the falling edge and set the next i_ce.
    task automatic step();
        @(negedge i_clk);
        i_ce     = (ce_phase == 0);
        ce_phase = (ce_phase + 1) % ce_div;
    endtask

    // Send one packet; cancel_at is the index of the nibble accepted together
    // with i_cancel (>= n for none). rl counts ce edges with o_rdy low before
    // the first acceptance.
    task automatic send_pkt(input int n, input bit en_pre, input int cancel_at,
                            input logic [3:0] first, input bit rnd, output int rl);
        logic [3:0] data[$];
        int idx;
        int guard;
        for (int i = 0; i < n; i++) begin
            if (rnd) data.push_back(4'($urandom_range(0, 15)));
            else     data.push_back(first + 4'(i));
        end
        if (en_pre) begin
            for (int i = 0; i < 15; i++) exp_q.push_back(4'h5);
            exp_q.push_back(4'hd);
        end
        for (int i = 0; i < n && i < cancel_at; i++) exp_q.push_back(data[i]);
        idx   = 0;
        guard = 0;
        rl    = 0;
        while (idx < n && guard < 2000) begin
            step();
            guard++;
            // i_en flips once the packet is under way; it must not matter.
            i_en     = o_busy ? !en_pre : en_pre;
            i_v      = 1'b1;
            i_d      = data[idx];
            i_cancel = (idx == cancel_at);
            if (i_ce) begin
                if (o_rdy) idx++;
                else if (idx == 0) rl++;
            end
        end
        check("send_done", 32'(idx), 32'(n));
        do begin
            step();
            i_v      = 1'b0;
            i_cancel = 1'b0;
        end while (!i_ce);
        low_run = 0;
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        while (o_busy && g < 400) begin
            step();
            g++;
        end
        check("idle_reached", {31'd0, o_busy}, 32'd0);
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (exp_q.size() > 0 && g < 400) begin
            step();
            g++;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int g;
        i_reset_n = 1'b0;
        i_ce      = 1'b1;
        i_en      = 1'b1;
        i_cancel  = 1'b0;
        i_v       = 1'b0;
        i_d       = 4'h0;
        repeat (3) step();
        check("rst_v",    {31'd0, o_v},    32'd0);
        check("rst_d",    {28'd0, o_d},    32'd0);
        check("rst_busy", {31'd0, o_busy}, 32'd0);
        check("rst_rdy",  {31'd0, o_rdy},  32'd0);
        i_reset_n = 1'b1;

        // Preamble packet 1,2,3,4 straight after reset, then back-to-back packet.
        send_pkt(4, 1'b1, 99, 4'h1, 1'b0, rdy_low);
        check("rdy_low_first", 32'(rdy_low), 32'd16);
        send_pkt(4, 1'b1, 99, 4'h0, 1'b1, rdy_low);
        drain();
        check("b2b_gap", 32'(last_gap), 32'd24);

        // ce pulsing one clock in four.
        wait_idle();
        ce_div   = 4;
        ce_phase = 0;
        send_pkt(4, 1'b1, 99, 4'h1, 1'b0, rdy_low);
        check("rdy_low_ce4", 32'(rdy_low), 32'd16);
        drain();
        wait_idle();
        ce_div   = 1;
        ce_phase = 0;

        // Pass-through: A,B,C with no preamble or SFD.
        send_pkt(3, 1'b0, 99, 4'ha, 1'b0, rdy_low);
        check("rdy_low_pass", 32'(rdy_low), 32'd1);
        drain();
        wait_idle();

        // Cancel while the 3rd data nibble is on the wire, then measure the gap.
        send_pkt(10, 1'b1, 3, 4'h0, 1'b1, rdy_low);
        send_pkt(2, 1'b1, 99, 4'h7, 1'b0, rdy_low);
        drain();
        check("cancel_gap", 32'(last_gap), 32'd24);
        wait_idle();

        // Cancel in IDLE suppresses the start.
        i_en     = 1'b1;
        i_v      = 1'b1;
        i_cancel = 1'b1;
        repeat (3) step();
        i_v      = 1'b0;
        i_cancel = 1'b0;
        step();
        check("idle_cancel_busy", {31'd0, o_busy}, 32'd0);
        check("idle_cancel_v",    {31'd0, o_v},    32'd0);

        // Asynchronous reset during the 7th preamble nibble.
        for (int i = 0; i < 15; i++) exp_q.push_back(4'h5);
        exp_q.push_back(4'hd);
        i_v = 1'b1;
        g   = 0;
        while (exp_q.size() > 9 && g < 100) begin
            step();
            g++;
        end
        check("pre7_reached", 32'(exp_q.size()), 32'd9);
        check("pre7_v", {31'd0, o_v}, 32'd1);
        #2;
        i_reset_n = 1'b0;
        #1;
        check("arst_v",    {31'd0, o_v},    32'd0);
        check("arst_d",    {28'd0, o_d},    32'd0);
        check("arst_busy", {31'd0, o_busy}, 32'd0);
        check("arst_rdy",  {31'd0, o_rdy},  32'd0);
        exp_q.delete();
        i_v = 1'b0;
        repeat (2) step();
        i_reset_n = 1'b1;
        send_pkt(3, 1'b1, 99, 4'h9, 1'b0, rdy_low);
        check("rdy_low_after_rst", 32'(rdy_low), 32'd16);
        drain();
        wait_idle();
        check("final_queue", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
